partition_error_monitor: RTL and testbench

- Self-contained hardware scoring engine for a partitioned approximate sub-circuit.
- Drives every input vector of the partition exhaustively, in ascending order.
- Samples the approximate and exact outputs for each vector and accumulates error metrics (mismatch count, Hamming distance, absolute error).
- Replaces the print-and-diff flow with on-chip or emulator scoring; sits between a partition instance, its exact reference, and a host/CSR reader.

---
 rtl/partition_error_monitor_if.sv | 33 +++
 rtl/partition_error_monitor.sv | 167 ++++++++++++++++
 tb/tb_partition_error_monitor.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/partition_error_monitor_if.sv
// Bundle of control, stimulus, sampled-output and result signals between the error
// monitor (slave) and the partition pair plus host that drive it (master).
interface partition_error_monitor_if #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
);
    localparam int CNT_W = IN_W + 1;
    localparam int HAM_W = IN_W + $clog2(OUT_W + 1);
    localparam int ABS_W = IN_W + OUT_W;

    logic             start;
    logic             abort;
    logic [IN_W-1:0]  pi;
    logic [OUT_W-1:0] po_approx;
    logic [OUT_W-1:0] po_exact;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [HAM_W-1:0] ham_sum;
    logic [ABS_W-1:0] abs_sum;
    logic [OUT_W-1:0] max_abs;

    modport master (
        output start, abort, po_approx, po_exact,
        input  pi, busy, done, vec_count, err_count, ham_sum, abs_sum, max_abs
    );

    modport slave (
        input  start, abort, po_approx, po_exact,
        output pi, busy, done, vec_count, err_count, ham_sum, abs_sum, max_abs
    );
endinterface

// File: rtl/partition_error_monitor.sv
// Exhaustive sweep of a partition's input space, scoring the approximate output against
// the exact reference: mismatch count, Hamming distance, absolute error sum and maximum.
module partition_error_monitor #(
    parameter int IN_W   = 7,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    partition_error_monitor_if.slave bus
);
    localparam int CNT_W = IN_W + 1;
    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int HAM_W = IN_W + PC_W;
    localparam int ABS_W = IN_W + OUT_W;
    localparam logic [IN_W-1:0] PI_LAST     = {IN_W{1'b1}};
    localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    state_t           state_r, state_s;
    logic [IN_W-1:0]  pi_r, pi_s;
    logic [7:0]       settle_r, settle_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [CNT_W-1:0] vec_r, vec_s;
    logic [CNT_W-1:0] err_r, err_s;
    logic [HAM_W-1:0] ham_r, ham_s;
    logic [ABS_W-1:0] abs_r, abs_s;
    logic [OUT_W-1:0] max_r, max_s;

    logic [OUT_W:0]   diff_s;
    logic [OUT_W:0]   neg_diff_s;
    logic [OUT_W-1:0] abs_diff_s;
    logic             mismatch_s;

    // Per-vector error metrics; the difference is taken one bit wider so its sign is visible.
    always_comb begin
        diff_s     = {1'b0, bus.po_approx} - {1'b0, bus.po_exact};
        neg_diff_s = {(OUT_W+1){1'b0}} - diff_s;
        mismatch_s = (bus.po_approx != bus.po_exact);
        if (diff_s[OUT_W]) begin
            abs_diff_s = neg_diff_s[OUT_W-1:0];
        end else begin
            abs_diff_s = diff_s[OUT_W-1:0];
        end
    end

    // Sweep sequencing, accumulation and status flags derived from the next state.
    always_comb begin
        state_s  = state_r;
        pi_s     = pi_r;
        settle_s = settle_r;
        vec_s    = vec_r;
        err_s    = err_r;
        ham_s    = ham_r;
        abs_s    = abs_r;
        max_s    = max_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_s  = S_WAIT;
                    pi_s     = {IN_W{1'b0}};
                    settle_s = SETTLE_INIT;
                    vec_s    = {CNT_W{1'b0}};
                    err_s    = {CNT_W{1'b0}};
                    ham_s    = {HAM_W{1'b0}};
                    abs_s    = {ABS_W{1'b0}};
                    max_s    = {OUT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_s = S_DONE;
                end else if (settle_r == 8'd0) begin
                    state_s = S_SAMPLE;
                end else begin
                    settle_s = settle_r - 8'd1;
                end
            end
            S_SAMPLE: begin
                vec_s = vec_r + CNT_W'(1'b1);
                err_s = err_r + CNT_W'(mismatch_s);
                ham_s = ham_r + HAM_W'(popcount(bus.po_approx ^ bus.po_exact));
                abs_s = abs_r + ABS_W'(abs_diff_s);
                if (abs_diff_s > max_r) begin
                    max_s = abs_diff_s;
                end else begin
                    max_s = max_r;
                end
                // An abort here still scores the vector but leaves pi on it.
                if (bus.abort || (pi_r == PI_LAST)) begin
                    state_s = S_DONE;
                end else begin
                    pi_s     = pi_r + IN_W'(1'b1);
                    settle_s = SETTLE_INIT;
                    state_s  = S_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        if ((state_s == S_WAIT) || (state_s == S_SAMPLE)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (state_s == S_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            pi_r     <= {IN_W{1'b0}};
            settle_r <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            vec_r    <= {CNT_W{1'b0}};
            err_r    <= {CNT_W{1'b0}};
            ham_r    <= {HAM_W{1'b0}};
            abs_r    <= {ABS_W{1'b0}};
            max_r    <= {OUT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            pi_r     <= pi_s;
            settle_r <= settle_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            vec_r    <= vec_s;
            err_r    <= err_s;
            ham_r    <= ham_s;
            abs_r    <= abs_s;
            max_r    <= max_s;
        end
    end

    assign bus.pi        = pi_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.vec_count = vec_r;
    assign bus.err_count = err_r;
    assign bus.ham_sum   = ham_r;
    assign bus.abs_sum   = abs_r;
    assign bus.max_abs   = max_r;
endmodule

// File: tb/tb_partition_error_monitor.sv
// Bench for partition_error_monitor: table-driven partition outputs (fixed patterns and
// random), scored against a straightforward arithmetic model of the sweep.
module tb_partition_error_monitor;
    localparam int IN_W   = 7;
    localparam int OUT_W  = 4;
    localparam int SETTLE = 1;
    localparam int NVEC   = 1 << IN_W;
    localparam int SWEEP  = NVEC * (SETTLE + 2);
    localparam int CNT_W  = IN_W + 1;
    localparam int HAM_W  = IN_W + $clog2(OUT_W + 1);
    localparam int ABS_W  = IN_W + OUT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    partition_error_monitor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    logic [OUT_W-1:0] approx_tbl [NVEC];
    logic [OUT_W-1:0] exact_tbl  [NVEC];
    assign bus.po_approx = approx_tbl[bus.pi];
    assign bus.po_exact  = exact_tbl[bus.pi];

    partition_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_vec, exp_err, exp_ham, exp_abs, exp_max;

    // mode 0 identity, 1 LSB flipped, 2 bit3 stuck at 0, 3 random
    task automatic fill_tables(input int mode);
        for (int v = 0; v < NVEC; v++) begin
            logic [IN_W-1:0]  vv;
            logic [OUT_W-1:0] e, a;
            vv = v[IN_W-1:0];
            e  = vv[OUT_W-1:0];
            case (mode)
                0: a = e;
                1: a = e ^ 4'b0001;
                2: a = {1'b0, e[2:0]};
                3: begin
                    e = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) a = e;
                    else a = 4'($urandom_range(0, 15));
                end
                default: a = e;
            endcase
            approx_tbl[v] = a;
            exact_tbl[v]  = e;
        end
    endtask

    task automatic model(input int n);
        exp_vec = n; exp_err = 0; exp_ham = 0; exp_abs = 0; exp_max = 0;
        for (int v = 0; v < n; v++) begin
            int d;
            d = int'(approx_tbl[v]) - int'(exact_tbl[v]);
            if (d < 0) d = -d;
            if (d != 0) exp_err++;
            exp_ham += $countones(approx_tbl[v] ^ exact_tbl[v]);
            exp_abs += d;
            if (d > exp_max) exp_max = d;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2 * SWEEP) begin
            @(negedge clk);
            cyc++;
        end
        to = (bus.done !== 1'b1);
    endtask

    task automatic wait_pi(input int target, output bit to);
        int i;
        i = 0;
        while (bus.pi !== IN_W'(target) && i < 2 * SWEEP) begin
            @(negedge clk);
            i++;
        end
        to = (bus.pi !== IN_W'(target));
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
        fill_tables(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pi !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_count !== '0 ||
            bus.err_count !== '0 || bus.ham_sum !== '0 || bus.abs_sum !== '0 || bus.max_abs !== '0) begin
            failures++;
            $display("FAIL reset_state: pi=%0d busy=%b done=%b vec=%0d err=%0d ham=%0d abs=%0d max=%0d, required all zero",
                     bus.pi, bus.busy, bus.done, bus.vec_count, bus.err_count, bus.ham_sum, bus.abs_sum, bus.max_abs);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b done=%b, required busy=0 done=0", bus.busy, bus.done);
        end
    endtask

    task automatic test_sweep(input int mode, input string name);
        int cyc; bit to;
        fill_tables(mode);
        model(NVEC);
        pulse_start();
        wait_done(cyc, to);
        checks++;
        if (to || cyc != SWEEP) begin
            failures++;
            $display("FAIL %s_latency: cycles=%0d timeout=%0d, required %0d", name, cyc, to, SWEEP);
        end
        checks++;
        if (bus.vec_count !== CNT_W'(exp_vec) || bus.err_count !== CNT_W'(exp_err)) begin
            failures++;
            $display("FAIL %s_counts: vec=%0d err=%0d, required vec=%0d err=%0d",
                     name, bus.vec_count, bus.err_count, exp_vec, exp_err);
        end
        checks++;
        if (bus.ham_sum !== HAM_W'(exp_ham) || bus.abs_sum !== ABS_W'(exp_abs) || bus.max_abs !== OUT_W'(exp_max)) begin
            failures++;
            $display("FAIL %s_sums: ham=%0d abs=%0d max=%0d, required ham=%0d abs=%0d max=%0d",
                     name, bus.ham_sum, bus.abs_sum, bus.max_abs, exp_ham, exp_abs, exp_max);
        end
        checks++;
        if (bus.pi !== IN_W'(NVEC - 1) || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_final: pi=%0d busy=%b, required pi=%0d busy=0", name, bus.pi, bus.busy, NVEC - 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.vec_count !== CNT_W'(exp_vec)) begin
            failures++;
            $display("FAIL %s_hold: done=%b vec=%0d, required done=1 vec=%0d", name, bus.done, bus.vec_count, exp_vec);
        end
    endtask

    task automatic test_abort_wait();
        bit to;
        fill_tables(0);
        pulse_start();
        wait_pi(10, to);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        checks++;
        if (to || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.vec_count !== CNT_W'(10) || bus.pi !== IN_W'(10)) begin
            failures++;
            $display("FAIL abort_wait: timeout=%0d done=%b busy=%b vec=%0d pi=%0d, required done=1 busy=0 vec=10 pi=10",
                     to, bus.done, bus.busy, bus.vec_count, bus.pi);
        end
    endtask

    task automatic test_abort_sample();
        bit to;
        fill_tables(3);
        model(11);
        pulse_start();
        wait_pi(10, to);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        checks++;
        if (to || bus.done !== 1'b1 || bus.vec_count !== CNT_W'(11) || bus.pi !== IN_W'(10)) begin
            failures++;
            $display("FAIL abort_sample: timeout=%0d done=%b vec=%0d pi=%0d, required done=1 vec=11 pi=10",
                     to, bus.done, bus.vec_count, bus.pi);
        end
        checks++;
        if (bus.err_count !== CNT_W'(exp_err) || bus.ham_sum !== HAM_W'(exp_ham) ||
            bus.abs_sum !== ABS_W'(exp_abs) || bus.max_abs !== OUT_W'(exp_max)) begin
            failures++;
            $display("FAIL abort_sample_partial: err=%0d ham=%0d abs=%0d max=%0d, required err=%0d ham=%0d abs=%0d max=%0d",
                     bus.err_count, bus.ham_sum, bus.abs_sum, bus.max_abs, exp_err, exp_ham, exp_abs, exp_max);
        end
    endtask

    task automatic test_start_abort_together();
        int cyc; bit to;
        @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.vec_count !== '0 || bus.err_count !== '0 || bus.pi !== '0) begin
            failures++;
            $display("FAIL start_over_abort: busy=%b done=%b vec=%0d err=%0d pi=%0d, required busy=1 done=0 vec=0 err=0 pi=0",
                     bus.busy, bus.done, bus.vec_count, bus.err_count, bus.pi);
        end
        wait_done(cyc, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL start_over_abort_finish: timeout after %0d cycles, required done", cyc);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        fill_tables(3);
        model(NVEC);
        pulse_start();
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 2 * SWEEP) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == 100);
        end
        bus.start = 1'b0;
        checks++;
        if (cyc != SWEEP || bus.vec_count !== CNT_W'(exp_vec) || bus.abs_sum !== ABS_W'(exp_abs)) begin
            failures++;
            $display("FAIL start_ignored: cycles=%0d vec=%0d abs=%0d, required cycles=%0d vec=%0d abs=%0d",
                     cyc, bus.vec_count, bus.abs_sum, SWEEP, exp_vec, exp_abs);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to;
        fill_tables(1);
        pulse_start();
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (bus.pi !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_count !== '0 ||
            bus.err_count !== '0 || bus.ham_sum !== '0 || bus.abs_sum !== '0 || bus.max_abs !== '0) begin
            failures++;
            $display("FAIL reset_mid: pi=%0d busy=%b done=%b vec=%0d err=%0d ham=%0d abs=%0d max=%0d, required all zero",
                     bus.pi, bus.busy, bus.done, bus.vec_count, bus.err_count, bus.ham_sum, bus.abs_sum, bus.max_abs);
        end
        model(NVEC);
        pulse_start();
        wait_done(cyc, to);
        checks++;
        if (to || cyc != SWEEP || bus.vec_count !== CNT_W'(exp_vec) || bus.err_count !== CNT_W'(exp_err)) begin
            failures++;
            $display("FAIL reset_mid_rerun: cycles=%0d vec=%0d err=%0d, required cycles=%0d vec=%0d err=%0d",
                     cyc, bus.vec_count, bus.err_count, SWEEP, exp_vec, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_abort_idle();
        test_sweep(0, "identity");
        test_sweep(1, "lsb_flip");
        test_sweep(2, "bit3_stuck");
        test_sweep(3, "random_a");
        test_sweep(3, "random_b");
        test_abort_wait();
        test_abort_sample();
        test_start_abort_together();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
